sm_debug_reader: RTL and testbench

//   Reader on the CPU debug register port. It drives regAddr and samples regData,

---
 rtl/sm_debug_reader.sv | 108 ++++++++++
 tb/tb_sm_debug_reader.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_debug_reader.sv
// Debug-port reader: one register (single mode) or FIRST_REG..LAST_REG (scan) as addr-tagged valid/ready beats.
// Latency SETTLE_CYCLES from start to outValid; a beat is held until outReady and the scan stalls behind it.
module sm_debug_reader #(
    parameter int SETTLE_CYCLES = 1,
    parameter int FIRST_REG     = 0,
    parameter int LAST_REG      = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode,
    input  logic [4:0]  reqAddr,
    input  logic        stop,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        outValid,
    input  logic        outReady,
    output logic [4:0]  outAddr,
    output logic [31:0] outData,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SETTLE, OUTPUT} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);
    localparam logic [4:0] FIRST_ADDR  = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR   = 5'(LAST_REG);

    state_t     state;
    state_t     nextState;
    logic [7:0] cnt;
    logic       scanMode;
    logic       stopPending;
    logic       launch;
    logic       captureNow;
    logic       handshake;
    logic       lastBeat;

    assign launch     = (state == IDLE) && start;
    assign captureNow = (state == SETTLE) && (cnt == 8'd1);
    assign handshake  = (state == OUTPUT) && outValid && outReady;
    // A stop arriving on the handshake edge itself also ends the scan after this beat.
    assign lastBeat   = !scanMode || (regAddr == LAST_ADDR) || stopPending || stop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (start) nextState = SETTLE;
            SETTLE:  if (cnt == 8'd1) nextState = OUTPUT;
            OUTPUT:  if (handshake) nextState = lastBeat ? IDLE : SETTLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regAddr  <= '0;
            cnt      <= '0;
            scanMode <= 1'b0;
        end else if (launch) begin
            scanMode <= mode;
            regAddr  <= mode ? FIRST_ADDR : reqAddr;
            cnt      <= SETTLE_LOAD;
        end else if (state == SETTLE) begin
            cnt <= cnt - 8'd1;
        end else if (handshake && !lastBeat) begin
            regAddr <= regAddr + 5'd1;
            cnt     <= SETTLE_LOAD;
        end
    end

    // Captured beat: address and data only change at capture, so reqAddr is free after start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid <= 1'b0;
            outAddr  <= '0;
            outData  <= '0;
        end else if (captureNow) begin
            outValid <= 1'b1;
            outAddr  <= regAddr;
            outData  <= regData;
        end else if (handshake) begin
            outValid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stopPending <= 1'b0;
        end else if (nextState == IDLE) begin
            stopPending <= 1'b0;
        end else if ((state != IDLE) && stop) begin
            stopPending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sm_debug_reader.sv
// Bench: dutA (settle 1, scan 0..31, combinational regData) and dutB (settle 3, scan 3..6, regData lags regAddr by a cycle).
module tb_sm_debug_reader;
    typedef struct {
        logic [4:0]  reqAddr;
        int          rdyDelay;
        logic [4:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        int          dut;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic        mode [2];
    logic [4:0]  reqAddr [2];
    logic        stop [2];
    logic        outReady [2];
    logic [31:0] rf [32];

    logic [4:0]  aRegAddr, bRegAddr, aOutAddr, bOutAddr;
    logic [31:0] aRegData, bRegData, aOutData, bOutData;
    logic        aOutValid, bOutValid, aBusy, bBusy;

    logic        outValid [2];
    logic [4:0]  outAddr [2];
    logic [31:0] outData [2];
    logic [4:0]  regAddr [2];
    logic        busy [2];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    beat_t       got [$];
    beat_t       expQ [$];
    logic        hold [2];
    logic [4:0]  holdAddr [2];
    logic [31:0] holdData [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_debug_reader #(.SETTLE_CYCLES(1), .FIRST_REG(0), .LAST_REG(31)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode[0]), .reqAddr(reqAddr[0]),
        .stop(stop[0]), .regAddr(aRegAddr), .regData(aRegData), .outValid(aOutValid),
        .outReady(outReady[0]), .outAddr(aOutAddr), .outData(aOutData), .busy(aBusy)
    );

    sm_debug_reader #(.SETTLE_CYCLES(3), .FIRST_REG(3), .LAST_REG(6)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode[1]), .reqAddr(reqAddr[1]),
        .stop(stop[1]), .regAddr(bRegAddr), .regData(bRegData), .outValid(bOutValid),
        .outReady(outReady[1]), .outAddr(bOutAddr), .outData(bOutData), .busy(bBusy)
    );

    // CPU debug ports: immediate for dutA, one cycle late for dutB.
    always_comb aRegData = rf[aRegAddr];
    always @(posedge clk) bRegData <= rf[bRegAddr];

    always_comb begin
        outValid[0] = aOutValid; outValid[1] = bOutValid;
        outAddr[0]  = aOutAddr;  outAddr[1]  = bOutAddr;
        outData[0]  = aOutData;  outData[1]  = bOutData;
        regAddr[0]  = aRegAddr;  regAddr[1]  = bRegAddr;
        busy[0]     = aBusy;     busy[1]     = bBusy;
    end

    function automatic int settleOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic int firstOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction
    function automatic int lastOf(input int d);
        return (d == 0) ? 31 : 6;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int d, input int a);
        beat_t b;
        b.dut = d; b.addr = 5'(a); b.data = rf[a]; b.cyc = 0;
        expQ.push_back(b);
    endtask

    task automatic compareBeats(input string name);
        chk(name, 32'(got.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < got.size(); i++) begin
            chk("beat dut", 32'(got[i].dut), 32'(expQ[i].dut));
            chk("beat addr", 32'(got[i].addr), 32'(expQ[i].addr));
            chk("beat data", got[i].data, expQ[i].data);
        end
    endtask

    task automatic runUntilIdle(input int d, input int readyPct, input int bound, output int cycles);
        cycles = 0;
        while (busy[d] && cycles < bound) begin
            outReady[d] = ($urandom_range(0, 99) < readyPct);
            step();
            cycles++;
        end
        outReady[d] = 1'b0;
        chk("idle within bound", 32'(busy[d]), 32'd0);
    endtask

    task automatic singleRead(input int d, input logic [4:0] a, input int delay,
                              input logic [4:0] expAddr, input logic [31:0] expData);
        start[d] = 1'b1; mode[d] = 1'b0; reqAddr[d] = a;
        step();
        start[d] = 1'b0; reqAddr[d] = ~a;
        chk("busy after start", 32'(busy[d]), 32'd1);
        chk("valid at start edge", 32'(outValid[d]), 32'd0);
        for (int k = 1; k <= settleOf(d); k++) begin
            step();
            chk("latency valid", 32'(outValid[d]), 32'(k == settleOf(d)));
        end
        chk("single regAddr", 32'(regAddr[d]), 32'(a));
        chk("single addr", 32'(outAddr[d]), 32'(expAddr));
        chk("single data", outData[d], expData);
        for (int k = 0; k < delay; k++) begin
            step();
            chk("stall valid", 32'(outValid[d]), 32'd1);
            chk("stall addr", 32'(outAddr[d]), 32'(expAddr));
            chk("stall data", outData[d], expData);
        end
        outReady[d] = 1'b1;
        step();
        outReady[d] = 1'b0;
        chk("valid after handshake", 32'(outValid[d]), 32'd0);
        chk("busy after handshake", 32'(busy[d]), 32'd0);
    endtask

    // Stream monitor: logs accepted beats and checks a stalled beat does not move.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                hold[d] = 1'b0;
            end else begin
                if (hold[d]) begin
                    chk("hold valid", 32'(outValid[d]), 32'd1);
                    chk("hold addr", 32'(outAddr[d]), 32'(holdAddr[d]));
                    chk("hold data", outData[d], holdData[d]);
                end
                if (outValid[d] && outReady[d]) begin
                    beat_t b;
                    b.dut = d; b.addr = outAddr[d]; b.data = outData[d]; b.cyc = cyc;
                    got.push_back(b);
                end
                hold[d]     = outValid[d] && !outReady[d];
                holdAddr[d] = outAddr[d];
                holdData[d] = outData[d];
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        int   n;
        int   e;
        int   d;
        logic m;
        logic [4:0] a;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; mode[i] = 1'b0; reqAddr[i] = '0; stop[i] = 1'b0; outReady[i] = 1'b0;
            hold[i] = 1'b0; holdAddr[i] = '0; holdData[i] = '0;
        end
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        vecs[0] = '{5'd5,  3, 5'd5,  32'h0000_00A5};
        vecs[1] = '{5'd0,  0, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{5'd31, 1, 5'd31, 32'h1F1F_1F1F};
        vecs[3] = '{5'd17, 2, 5'd17, 32'h1111_1111};

        #12;
        for (int i = 0; i < 2; i++) begin
            chk("reset regAddr", 32'(regAddr[i]), 32'd0);
            chk("reset valid", 32'(outValid[i]), 32'd0);
            chk("reset outAddr", 32'(outAddr[i]), 32'd0);
            chk("reset outData", outData[i], 32'd0);
            chk("reset busy", 32'(busy[i]), 32'd0);
        end
        #5 rst_n = 1'b1;
        step();

        // Single reads from the vector table; PC appears at address 0.
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h0000_00A5;
        for (int i = 0; i < 4; i++)
            singleRead(0, vecs[i].reqAddr, vecs[i].rdyDelay, vecs[i].expAddr, vecs[i].expData);

        // Full scan at full rate: one beat every 2 cycles.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        got.delete(); expQ.delete();
        for (int r = 0; r < 32; r++) pushExp(0, r);
        start[0] = 1'b1; mode[0] = 1'b1; step(); start[0] = 1'b0;
        runUntilIdle(0, 100, 200, n);
        chk("scan cycles", 32'(n), 32'd64);
        compareBeats("scan beat count");
        for (int i = 1; i < got.size(); i++)
            chk("scan spacing", 32'(got[i].cyc - got[i-1].cyc), 32'd2);

        // Random data and modes with 30% ready.
        for (int it = 0; it < 10; it++) begin
            d = it % 2;
            m = (it < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            a = 5'($urandom_range(0, 31));
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            got.delete(); expQ.delete();
            if (m) begin
                for (int r = firstOf(d); r <= lastOf(d); r++) pushExp(d, r);
            end else begin
                pushExp(d, int'(a));
            end
            start[d] = 1'b1; mode[d] = m; reqAddr[d] = a; step();
            start[d] = 1'b0; reqAddr[d] = 5'($urandom);
            runUntilIdle(d, 30, 3000, n);
            compareBeats("random beat count");
        end

        // Stop during the settle of address 10, plus an ignored start while busy.
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        got.delete(); expQ.delete();
        for (int r = 0; r <= 10; r++) pushExp(0, r);
        start[0] = 1'b1; mode[0] = 1'b1; outReady[0] = 1'b1; step(); start[0] = 1'b0;
        e = 0;
        while (e < 60) begin
            e++;
            stop[0] = (e == 21);
            start[0] = (e == 5);
            if (e == 5) begin mode[0] = 1'b0; reqAddr[0] = 5'd3; end
            step();
            if (!busy[0]) break;
        end
        stop[0] = 1'b0; start[0] = 1'b0; outReady[0] = 1'b0;
        chk("stop end edge", 32'(e), 32'd22);
        compareBeats("stop beat count");

        // Stop on the final handshake edge of a dutB scan.
        got.delete(); expQ.delete();
        for (int r = 3; r <= 6; r++) pushExp(1, r);
        start[1] = 1'b1; mode[1] = 1'b1; outReady[1] = 1'b1; step(); start[1] = 1'b0;
        e = 0;
        while (e < 60) begin
            e++;
            stop[1] = (e == 16);
            step();
            if (!busy[1]) break;
        end
        stop[1] = 1'b0; outReady[1] = 1'b0;
        chk("final stop end edge", 32'(e), 32'd16);
        compareBeats("final stop beat count");

        // Stop in idle is ignored; the next scan runs to completion.
        stop[1] = 1'b1; step(); stop[1] = 1'b0;
        got.delete(); expQ.delete();
        for (int r = 3; r <= 6; r++) pushExp(1, r);
        start[1] = 1'b1; mode[1] = 1'b1; step(); start[1] = 1'b0;
        runUntilIdle(1, 100, 100, n);
        chk("dutB scan cycles", 32'(n), 32'd16);
        compareBeats("dutB scan beat count");

        // Settle of 3 must capture the late-arriving value for the new address.
        singleRead(1, 5'd9, 1, 5'd9, 32'h0909_0909);

        // Asynchronous reset while a beat is waiting.
        start[0] = 1'b1; mode[0] = 1'b0; reqAddr[0] = 5'd7; step(); start[0] = 1'b0;
        step();
        chk("pre-reset valid", 32'(aOutValid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(aOutValid), 32'd0);
        chk("async reset regAddr", 32'(aRegAddr), 32'd0);
        chk("async reset busy", 32'(aBusy), 32'd0);
        chk("async reset outAddr", 32'(aOutAddr), 32'd0);
        chk("async reset outData", aOutData, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        singleRead(0, 5'd12, 1, 5'd12, 32'h0C0C_0C0C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
